// File: rtl/port_bridge.sv
// port_bridge: CPU 16-bit I/O port endpoint (out FIFO + in holding register).
// Optional PORT_BRIDGE_DROPCNT_EN adds a saturating drop_cnt output.
module port_bridge #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          out_wr,
  input  logic [15:0]   out_data,
  output logic          m_valid,
  output logic [15:0]   m_data,
  input  logic          m_ready,
  input  logic          s_valid,
  input  logic [15:0]   s_data,
  output logic          s_ready,
  output logic [15:0]   in_port,
  output logic          in_valid,
  input  logic          in_ack,
`ifdef PORT_BRIDGE_DROPCNT_EN
  output logic [7:0]    drop_cnt,
`endif
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;
  logic          capture;

  // Handshake qualifiers; none depends on m_ready->m_valid or s_valid->s_ready
  always_comb begin
    m_valid = (count != '0);
    pop     = m_valid && m_ready;
    push    = out_wr && ((count != FULL) || pop);
    drop    = out_wr && (count == FULL) && !pop;
    m_data  = m_valid ? mem[rd_ptr] : 16'h0000;
    s_ready = !in_valid || in_ack;
    capture = s_valid && s_ready;
  end

  // FIFO storage, no reset needed on the array
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= out_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

`ifdef PORT_BRIDGE_DROPCNT_EN
  // Saturating count of dropped writes; overflow derived from it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt <= 8'd0;
    else if (drop && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'd1;
  end

  assign overflow = (drop_cnt != 8'd0);
`else
  // Sticky flag for any dropped write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
  end
`endif

  // In holding register; in_port keeps last word after ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_port  <= 16'h0000;
      in_valid <= 1'b0;
    end else if (capture) begin
      in_port  <= s_data;
      in_valid <= 1'b1;
    end else if (in_ack) begin
      in_valid <= 1'b0;
    end
  end

endmodule

// File: doc/port_bridge.md
Name: port_bridge

Overview:
- External-side endpoint of the CPU's 16-bit I/O port interface.
- Out direction: accepts CPU out-port write strobes and buffers the words in a DEPTH-entry FIFO. Drains them to a downstream consumer over a valid/ready handshake.
- In direction: accepts words from an external source over valid/ready and holds the word on in_port until the CPU acknowledges the IN.
- Sits between the core's I/O ports and the board-level peripheral fabric.

Parameters:
- DEPTH, 4, out-FIFO entries; power of two, 2..64.
- AW, 2, FIFO pointer width = log2(DEPTH).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- out_wr  input  1  CPU out-port write strobe (one word per high cycle).
- out_data  input  16  CPU out-port word.
- m_valid  output  1  FIFO head valid toward consumer.
- m_data  output  16  FIFO head word.
- m_ready  input  1  consumer accepts head.
- s_valid  input  1  external source word valid.
- s_data  input  16  external source word.
- s_ready  output  1  bridge can accept a source word.
- in_port  output  16  word presented to CPU in-port.
- in_valid  output  1  in_port holds an unconsumed word.
- in_ack  input  1  CPU consumed in_port (IN instruction retired).
- count  output  AW+1  out-FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky: an out_wr was dropped.

Behaviour:
- Reset (rst=0, async): wr/rd pointers=0, count=0, m_valid=0, m_data=0, overflow=0, in_port=0, in_valid=0. s_ready goes to 1 once reset is released. FIFO array contents are don't-care.
- Out FIFO:
  - push = out_wr && (count<DEPTH || pop).
  - pop = m_valid && m_ready.
  - m_valid = (count!=0).
  - m_data = array[rd_ptr], combinational read (first-word fall-through). A word written at edge N is visible on m_data/m_valid after edge N; pop is possible in cycle N+1.
  - Pointers are AW bits and wrap modulo DEPTH.
  - count: +1 on push only, -1 on pop only, unchanged on push&&pop.
  - Full with push&&pop in the same cycle: both happen and count stays DEPTH.
  - Empty: pop impossible; push makes m_valid=1 next cycle. No same-cycle bypass.
  - out_wr while count==DEPTH and !pop: word dropped, overflow<=1. overflow stays set until reset; FIFO contents unchanged.
  - m_data must stay stable while m_valid && !m_ready.
- In holding register:
  - s_ready = !in_valid || in_ack (combinational).
  - capture = s_valid && s_ready: in_port<=s_data, in_valid<=1.
  - in_ack && !capture: in_valid<=0. in_port keeps its last value, since the CPU in-register samples continuously.
  - in_ack with in_valid=0: ignored.
  - in_ack && s_valid on the same edge: new word captured, in_valid stays 1 (back-to-back, no bubble).
- Reset asserted mid-transfer: all state is cleared immediately; an in-flight handshake is lost. The source must re-present the word.
- No combinational path from m_ready to m_valid, or from s_valid to s_ready.

Optional Feature:
- Macro PORT_BRIDGE_DROPCNT_EN.
- Defined: adds output drop_cnt [7:0], reset 0. It increments on every dropped out_wr and saturates at 255. overflow = (drop_cnt!=0).
- Undefined: port absent; overflow is the 1-bit sticky flag described above.

Test Plan:
- Reset then idle -> m_valid=0, count=0, s_ready=1, in_valid=0, in_port=0x0000, overflow=0.
- out_wr with 0x1111, 0x2222, 0x3333 on consecutive cycles, m_ready=0 -> count=3, m_data=0x1111. Raise m_ready -> outputs 0x1111, 0x2222, 0x3333 in order, then m_valid=0.
- DEPTH=4, m_ready=0, 5 writes 0xA000..0xA004 -> count=4, overflow=1 (drop_cnt=1 if enabled). Drain yields 0xA000..0xA003 only.
- FIFO full, out_wr=1 with 0xBEEF and m_ready=1 same cycle -> head popped, 0xBEEF stored at tail, count stays 4, overflow unchanged.
- s_valid with 0x00C3 -> in_port=0x00C3, in_valid=1, s_ready=0. Next cycle in_ack=1 and s_valid=1 with 0x00C4 -> in_port=0x00C4, in_valid stays 1.
- Pull rst low for 1 cycle with count=2 and in_valid=1 -> all outputs at reset values immediately. First out_wr afterwards yields count=1.
